// File: rtl/sevenseg_mux.sv
// Time-multiplexed N-digit seven-segment driver: frame-coherent snapshot, LZ blanking, PWM dimming.
// Define SEVENSEG_HEX_EN to decode nibbles 10-15 as hex glyphs; otherwise they render dark.
module sevenseg_mux #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 100000,
  parameter int BRIGHT_W       = 4,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_suppress,
  input  logic [BRIGHT_W-1:0]     brightness,
  input  logic                    update,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_start
);

  localparam int SLOT_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRESC_W = $clog2(REFRESH_DIV);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);
  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(NUM_DIGITS - 1);
  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic DIG_INV = (DIG_ACTIVE_LOW != 0);

  logic [PRESC_W-1:0]      presc_reg, presc_next;
  logic [SLOT_W-1:0]       slot_reg, slot_next;
  logic [BRIGHT_W-1:0]     pwm_reg;
  logic [4*NUM_DIGITS-1:0] snap_digits_reg;
  logic [NUM_DIGITS-1:0]   snap_dp_reg, snap_blank_reg;
  logic                    pending_reg, pending_next;
  logic [6:0]              seg_reg, seg_next;
  logic                    dp_reg, dp_next;
  logic [NUM_DIGITS-1:0]   digit_reg, digit_next;
  logic                    frame_reg, frame_next;

  logic                    presc_wrap, frame_wrap, load_snap;
  logic [NUM_DIGITS-1:0]   slot_sel, upper_zero, dark;
  logic [3:0]              cur_nib;
  logic                    cur_lit, cur_dp, pwm_on, show;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
`ifdef SEVENSEG_HEX_EN
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      4'hF:    s = 7'h71;
`endif
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  assign presc_wrap = (presc_reg == PRESC_LAST);
  assign frame_wrap = presc_wrap && (slot_reg == SLOT_LAST);
  assign load_snap  = frame_wrap && (pending_reg || update);

  // upper_zero[k]: nibbles k..NUM_DIGITS-1 are all zero; digit 0 is never suppressed
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign slot_sel[gi] = (slot_reg == SLOT_W'(gi));
    if (gi == NUM_DIGITS - 1) begin : g_top
      assign upper_zero[gi] = (snap_digits_reg[4*gi +: 4] == 4'h0);
    end else begin : g_chain
      assign upper_zero[gi] = (snap_digits_reg[4*gi +: 4] == 4'h0) && upper_zero[gi+1];
    end
    assign dark[gi] = snap_blank_reg[gi] || (lz_suppress && upper_zero[gi] && (gi != 0));
  end

  always_comb begin
    cur_nib = 4'h0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (slot_sel[k]) cur_nib = cur_nib | snap_digits_reg[4*k +: 4];
    end
  end

  assign cur_lit = |(slot_sel & ~dark);
  assign cur_dp  = |(slot_sel & snap_dp_reg);
  assign pwm_on  = (&brightness) || (pwm_reg < brightness);
  assign show    = pwm_on && cur_lit;

  always_comb begin
    presc_next   = presc_wrap ? '0 : presc_reg + 1'b1;
    slot_next    = slot_reg;
    pending_next = pending_reg || update;
    if (presc_wrap) slot_next = (slot_reg == SLOT_LAST) ? '0 : slot_reg + 1'b1;
    if (load_snap) pending_next = 1'b0;
    seg_next   = (show ? decode(cur_nib) : 7'h00) ^ {7{SEG_INV}};
    dp_next    = (show && cur_dp) ^ SEG_INV;
    digit_next = (show ? slot_sel : '0) ^ {NUM_DIGITS{DIG_INV}};
    frame_next = (presc_reg == '0) && (slot_reg == '0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc_reg       <= '0;
      slot_reg        <= '0;
      pwm_reg         <= '0;
      snap_digits_reg <= '0;
      snap_dp_reg     <= '0;
      snap_blank_reg  <= '0;
      pending_reg     <= 1'b0;
      seg_reg         <= {7{SEG_INV}};
      dp_reg          <= SEG_INV;
      digit_reg       <= {NUM_DIGITS{DIG_INV}};
      frame_reg       <= 1'b0;
    end else begin
      presc_reg   <= presc_next;
      slot_reg    <= slot_next;
      pwm_reg     <= pwm_reg + 1'b1;
      pending_reg <= pending_next;
      if (load_snap) begin
        snap_digits_reg <= digits_in;
        snap_dp_reg     <= dp_in;
        snap_blank_reg  <= blank_in;
      end
      seg_reg   <= seg_next;
      dp_reg    <= dp_next;
      digit_reg <= digit_next;
      frame_reg <= frame_next;
    end
  end

  assign seg_out     = seg_reg;
  assign dp_out      = dp_reg;
  assign digit_en    = digit_reg;
  assign frame_start = frame_reg;

endmodule

// File: tb/tb_sevenseg_mux.sv
// Scoreboard bench for sevenseg_mux (4 digits, 4 clocks per slot, 2-bit brightness).
// Expected per-cycle words {frame_start, digit_en, dp_out, seg_out} are queued per frame and popped each cycle.
module tb_sevenseg_mux;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;
  logic        lz_suppress = 1'b0;
  logic [1:0]  brightness = 2'd3;
  logic        update = 1'b0;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  digit_en;
  logic        frame_start;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [12:0] sb_q[$];
  logic [12:0] exp_w, got_w;

`ifdef SEVENSEG_HEX_EN
  localparam logic [6:0] E_SEG = 7'h79;
`else
  localparam logic [6:0] E_SEG = 7'h00;
`endif

  sevenseg_mux #(
    .NUM_DIGITS(4), .REFRESH_DIV(4), .BRIGHT_W(2), .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)
  ) dut (
    .clock(clock), .reset(reset), .digits_in(digits_in), .dp_in(dp_in), .blank_in(blank_in),
    .lz_suppress(lz_suppress), .brightness(brightness), .update(update),
    .seg_out(seg_out), .dp_out(dp_out), .digit_en(digit_en), .frame_start(frame_start)
  );

  always #5 clock = ~clock;

  // Queue one 16-cycle frame of expected output words.
  task automatic push_frame(input logic [27:0] segs, input logic [3:0] lit,
                            input logic [3:0] dps, input logic [1:0] br);
    int s, p;
    logic on, l;
    logic [3:0] en;
    logic [6:0] sg;
    for (int c = 0; c < 16; c++) begin
      s  = c / 4;
      p  = c % 4;
      on = (br == 2'd3) || (p < int'(br));
      l  = on && lit[s];
      en = l ? (4'b0001 << s) : 4'b0000;
      sg = l ? segs[s*7 +: 7] : 7'h00;
      sb_q.push_back({(c == 0), en, (l && dps[s]), sg});
    end
  endtask

  task automatic wait_frame();
    int budget = 0;
    while (frame_start !== 1'b1 && budget < 100) begin
      @(negedge clock);
      budget++;
    end
    if (frame_start !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL frame_timeout: frame_start=%b after %0d cycles, required 1", frame_start, budget);
    end
  endtask

  task automatic pulse_update();
    update = 1'b1;
    @(negedge clock);
    update = 1'b0;
  endtask

  task automatic load_snapshot();
    wait_frame();
    pulse_update();
    wait_frame();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    got_w = {frame_start, digit_en, dp_out, seg_out};
    n_checks++;
    if (got_w !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_state: got=%h required=%h", got_w, 13'h0);
    end
    digits_in = 16'h1250;
    reset = 1'b1;
    @(negedge clock);
    push_frame({4{7'h3F}}, 4'b1111, 4'b0000, 2'd3);
    push_frame({7'h06, 7'h5B, 7'h6D, 7'h3F}, 4'b1111, 4'b0000, 2'd3);
    for (int c = 0; c < 32; c++) begin
      exp_w = sb_q.pop_front();
      got_w = {frame_start, digit_en, dp_out, seg_out};
      n_checks++;
      if (got_w !== exp_w) begin
        n_fail++;
        $display("FAIL scan_1250 cyc=%0d got=%h required=%h", c, got_w, exp_w);
      end
      if (c == 0) update = 1'b1;
      if (c == 1) update = 1'b0;
      @(negedge clock);
    end
  endtask

  task automatic test_lz_five();
    lz_suppress = 1'b1;
    digits_in = 16'h0005;
    load_snapshot();
    push_frame({21'h0, 7'h6D}, 4'b0001, 4'b0000, 2'd3);
    for (int c = 0; c < 16; c++) begin
      exp_w = sb_q.pop_front();
      got_w = {frame_start, digit_en, dp_out, seg_out};
      n_checks++;
      if (got_w !== exp_w) begin
        n_fail++;
        $display("FAIL lz_0005 cyc=%0d got=%h required=%h", c, got_w, exp_w);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_lz_zero();
    digits_in = 16'h0000;
    load_snapshot();
    push_frame({21'h0, 7'h3F}, 4'b0001, 4'b0000, 2'd3);
    for (int c = 0; c < 16; c++) begin
      exp_w = sb_q.pop_front();
      got_w = {frame_start, digit_en, dp_out, seg_out};
      n_checks++;
      if (got_w !== exp_w) begin
        n_fail++;
        $display("FAIL lz_0000 cyc=%0d got=%h required=%h", c, got_w, exp_w);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_midframe_update();
    lz_suppress = 1'b0;
    digits_in = 16'h1250;
    load_snapshot();
    push_frame({7'h06, 7'h5B, 7'h6D, 7'h3F}, 4'b1111, 4'b0000, 2'd3);
    push_frame({4{7'h6F}}, 4'b1111, 4'b0000, 2'd3);
    push_frame({4{7'h6F}}, 4'b1111, 4'b0000, 2'd3);
    for (int c = 0; c < 48; c++) begin
      exp_w = sb_q.pop_front();
      got_w = {frame_start, digit_en, dp_out, seg_out};
      n_checks++;
      if (got_w !== exp_w) begin
        n_fail++;
        $display("FAIL midframe_update cyc=%0d got=%h required=%h", c, got_w, exp_w);
      end
      if (c == 6)  begin digits_in = 16'h9999; update = 1'b1; end
      if (c == 7)  update = 1'b0;
      if (c == 10) update = 1'b1;
      if (c == 11) update = 1'b0;
      if (c == 16) digits_in = 16'h0000;
      @(negedge clock);
    end
  endtask

  task automatic test_brightness();
    brightness = 2'd1;
    @(negedge clock);
    wait_frame();
    push_frame({4{7'h6F}}, 4'b1111, 4'b0000, 2'd1);
    for (int c = 0; c < 16; c++) begin
      exp_w = sb_q.pop_front();
      got_w = {frame_start, digit_en, dp_out, seg_out};
      n_checks++;
      if (got_w !== exp_w) begin
        n_fail++;
        $display("FAIL bright_1 cyc=%0d got=%h required=%h", c, got_w, exp_w);
      end
      @(negedge clock);
    end
    brightness = 2'd0;
    @(negedge clock);
    wait_frame();
    push_frame({4{7'h6F}}, 4'b1111, 4'b0000, 2'd0);
    for (int c = 0; c < 16; c++) begin
      exp_w = sb_q.pop_front();
      got_w = {frame_start, digit_en, dp_out, seg_out};
      n_checks++;
      if (got_w !== exp_w) begin
        n_fail++;
        $display("FAIL bright_0 cyc=%0d got=%h required=%h", c, got_w, exp_w);
      end
      @(negedge clock);
    end
    brightness = 2'd3;
  endtask

  task automatic test_hex_dp_blank();
    digits_in = 16'h00E0;
    dp_in = 4'b0010;
    blank_in = 4'b1000;
    load_snapshot();
    push_frame({7'h3F, 7'h3F, E_SEG, 7'h3F}, 4'b0111, 4'b0010, 2'd3);
    for (int c = 0; c < 16; c++) begin
      exp_w = sb_q.pop_front();
      got_w = {frame_start, digit_en, dp_out, seg_out};
      n_checks++;
      if (got_w !== exp_w) begin
        n_fail++;
        $display("FAIL hex_dp_blank cyc=%0d got=%h required=%h", c, got_w, exp_w);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset_midframe();
    digits_in = 16'h8888;
    dp_in = 4'b0000;
    blank_in = 4'b0000;
    load_snapshot();
    repeat (9) @(negedge clock);
    got_w = {frame_start, digit_en, dp_out, seg_out};
    n_checks++;
    if (got_w !== {1'b0, 4'b0100, 1'b0, 7'h7F}) begin
      n_fail++;
      $display("FAIL pre_reset_slot2: got=%h required=%h", got_w, {1'b0, 4'b0100, 1'b0, 7'h7F});
    end
    #2 reset = 1'b0;
    #1;
    got_w = {frame_start, digit_en, dp_out, seg_out};
    n_checks++;
    if (got_w !== 13'h0) begin
      n_fail++;
      $display("FAIL async_reset: got=%h required=%h", got_w, 13'h0);
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    push_frame({4{7'h3F}}, 4'b1111, 4'b0000, 2'd3);
    for (int c = 0; c < 16; c++) begin
      exp_w = sb_q.pop_front();
      got_w = {frame_start, digit_en, dp_out, seg_out};
      n_checks++;
      if (got_w !== exp_w) begin
        n_fail++;
        $display("FAIL restart_after_reset cyc=%0d got=%h required=%h", c, got_w, exp_w);
      end
      @(negedge clock);
    end
  endtask

  initial begin
    test_reset();
    test_lz_five();
    test_lz_zero();
    test_midframe_update();
    test_brightness();
    test_hex_dp_blank();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
